// File: rtl/ddr_wr_burst_driver_if.sv
// Write-burst request handshake plus the DDR pin bundle serialized from it.
// master = sequencer side (drives the request), slave = burst driver (drives the pins).
interface ddr_wr_burst_driver_if #(
    parameter int DQ_WIDTH = 8,
    parameter int BL       = 8
);
    logic                   wr_valid;
    logic                   wr_ready;
    logic [DQ_WIDTH*BL-1:0] wr_data;
    logic                   ck_t;
    logic                   ck_c;
    logic                   dqs_t;
    logic                   dqs_c;
    logic                   dqs_oe;
    logic [DQ_WIDTH-1:0]    dq;
    logic                   dq_oe;
    logic                   busy;

    modport master (
        output wr_valid, wr_data,
        input  wr_ready, ck_t, ck_c, dqs_t, dqs_c, dqs_oe, dq, dq_oe, busy
    );

    modport slave (
        input  wr_valid, wr_data,
        output wr_ready, ck_t, ck_c, dqs_t, dqs_c, dqs_oe, dq, dq_oe, busy
    );
endinterface

// File: rtl/ddr_wr_burst_driver.sv
// DDR write-path pin driver: CK pair, DQS with 1-tCK preamble / half-tCK postamble, DQ beats.
// First beat 2*WL clk edges after accept; one burst in flight, wr_ready low until the burst retires.
module ddr_wr_burst_driver #(
    parameter int DQ_WIDTH = 8,
    parameter int BL       = 8,
    parameter int WL       = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ddr_wr_burst_driver_if.slave bus
);
    localparam int LAST_EDGE = 2*WL + BL + 1;
    localparam int CW        = $clog2(LAST_EDGE + 1);
    localparam logic [CW-1:0] PRE_EDGE  = CW'(2*WL - 2);
    localparam logic [CW-1:0] DATA_EDGE = CW'(2*WL);
    localparam logic [CW-1:0] POST_EDGE = CW'(2*WL + BL);

    if (BL != 4 && BL != 8) begin : g_bad_bl
        $error("ddr_wr_burst_driver: BL must be 4 or 8");
    end
    if (WL < 2) begin : g_bad_wl
        $error("ddr_wr_burst_driver: WL must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, WAIT, PRE, DATA, POST} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [DQ_WIDTH*BL-1:0] data_q;
    logic [DQ_WIDTH-1:0]    dq_q;
    logic                   ck_t_q;
    logic                   ck_t_d;
    logic                   dqs_t_q;
    logic                   dqs_oe_q;
    logic                   dq_oe_q;
    logic                   busy_q;
    logic                   wr_ready_q;
    logic                   accept;

    // cnt_q holds the index of the most recent edge counted from the accept edge
    assign cnt_d  = cnt_q + CW'(1);
    assign ck_t_d = ~ck_t_q;
    assign accept = bus.wr_valid && wr_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            dq_q       <= '0;
            ck_t_q     <= 1'b0;
            dqs_t_q    <= 1'b0;
            dqs_oe_q   <= 1'b0;
            dq_oe_q    <= 1'b0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
        end else begin
            ck_t_q     <= ck_t_d;
            wr_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= WAIT;
                        cnt_q   <= '0;
                        data_q  <= bus.wr_data;
                        busy_q  <= 1'b1;
                    end else begin
                        // ready only ahead of a CK rising edge so accepts stay tCK-aligned
                        wr_ready_q <= ~ck_t_d;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == PRE_EDGE) begin
                        state_q  <= PRE;
                        dqs_oe_q <= 1'b1;
                    end
                end
                PRE: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == DATA_EDGE) begin
                        state_q <= DATA;
                        dq_oe_q <= 1'b1;
                        dqs_t_q <= 1'b1;
                        dq_q    <= data_q[DQ_WIDTH-1:0];
                        data_q  <= data_q >> DQ_WIDTH;
                    end
                end
                DATA: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == POST_EDGE) begin
                        state_q <= POST;
                        dq_oe_q <= 1'b0;
                        dq_q    <= '0;
                        dqs_t_q <= 1'b0;
                    end else begin
                        dq_q    <= data_q[DQ_WIDTH-1:0];
                        data_q  <= data_q >> DQ_WIDTH;
                        dqs_t_q <= ~dqs_t_q;
                    end
                end
                POST: begin
                    state_q    <= IDLE;
                    cnt_q      <= '0;
                    dqs_oe_q   <= 1'b0;
                    busy_q     <= 1'b0;
                    wr_ready_q <= ~ck_t_d;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.wr_ready = wr_ready_q;
    assign bus.ck_t     = ck_t_q;
    assign bus.ck_c     = ~ck_t_q;
    assign bus.dqs_t    = dqs_t_q;
    assign bus.dqs_c    = ~dqs_t_q;
    assign bus.dqs_oe   = dqs_oe_q;
    assign bus.dq       = dq_q;
    assign bus.dq_oe    = dq_oe_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_ddr_wr_burst_driver.sv
// Bench for ddr_wr_burst_driver: WL=5/BL=8 and WL=2/BL=4 instances side by side.
// Expected beats are queued at accept time and popped by a monitor whenever dq_oe is high.
module tb_ddr_wr_burst_driver;
    localparam int DQW = 8;
    localparam int WLA = 5;
    localparam int BLA = 8;
    localparam int WLB = 2;
    localparam int BLB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        vld [2];
    logic [63:0] dat [2];
    logic [7:0]  pins [2];
    logic [7:0]  dqv [2];

    ddr_wr_burst_driver_if #(.DQ_WIDTH(DQW), .BL(BLA)) bus_a ();
    ddr_wr_burst_driver_if #(.DQ_WIDTH(DQW), .BL(BLB)) bus_b ();

    ddr_wr_burst_driver #(.DQ_WIDTH(DQW), .BL(BLA), .WL(WLA)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    ddr_wr_burst_driver #(.DQ_WIDTH(DQW), .BL(BLB), .WL(WLB)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    assign bus_a.wr_valid = vld[0];
    assign bus_a.wr_data  = dat[0];
    assign bus_b.wr_valid = vld[1];
    assign bus_b.wr_data  = dat[1][31:0];

    always_comb begin
        pins[0] = {bus_a.ck_t, bus_a.ck_c, bus_a.dqs_oe, bus_a.dqs_t, bus_a.dqs_c,
                   bus_a.dq_oe, bus_a.busy, bus_a.wr_ready};
        pins[1] = {bus_b.ck_t, bus_b.ck_c, bus_b.dqs_oe, bus_b.dqs_t, bus_b.dqs_c,
                   bus_b.dq_oe, bus_b.busy, bus_b.wr_ready};
        dqv[0]  = bus_a.dq;
        dqv[1]  = bus_b.dq;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, d, $time, act, exp);
        end
    endtask

    function automatic int wl_of(input int d);
        return (d == 0) ? WLA : WLB;
    endfunction

    function automatic int bl_of(input int d);
        return (d == 0) ? BLA : BLB;
    endfunction

    // Reference model: edge index since accept, CK phase and ready per the pin-timing rules
    int         m_n    [2];
    bit         m_busy [2];
    bit         m_ck   [2];
    bit         m_rdy  [2];
    int         m_acc  [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_n[d] = 0; m_busy[d] = 0; m_ck[d] = 0; m_rdy[d] = 1; m_acc[d] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    m_n[d] = 0; m_busy[d] = 0; m_ck[d] = 0; m_rdy[d] = 1;
                end
                q0.delete();
                q1.delete();
            end else begin
                for (int d = 0; d < 2; d++) begin
                    m_ck[d] = ~m_ck[d];
                    if (!m_busy[d]) begin
                        if (vld[d] && m_rdy[d]) begin
                            m_busy[d] = 1;
                            m_n[d]    = 0;
                            m_acc[d]++;
                            for (int k = 0; k < bl_of(d); k++) begin
                                if (d == 0) q0.push_back(dat[d][k*DQW +: DQW]);
                                else        q1.push_back(dat[d][k*DQW +: DQW]);
                            end
                        end
                    end else begin
                        m_n[d]++;
                        if (m_n[d] == 2*wl_of(d) + bl_of(d) + 1) m_busy[d] = 0;
                    end
                    m_rdy[d] = !m_busy[d] && !m_ck[d];
                end
            end
        end
    end

    // {ck_t, ck_c, dqs_oe, dqs_t, dqs_c, dq_oe, busy, wr_ready}
    function automatic logic [7:0] exp_pins(input int d);
        int   n, w2, b;
        logic oe_s, oe_d, st;
        n    = m_n[d];
        w2   = 2*wl_of(d);
        b    = bl_of(d);
        oe_s = m_busy[d] && (n >= w2 - 2) && (n <= w2 + b);
        oe_d = m_busy[d] && (n >= w2) && (n < w2 + b);
        st   = oe_d && (((n - w2) % 2) == 0);
        return {m_ck[d], ~m_ck[d], oe_s, st, ~st, oe_d, m_busy[d], m_rdy[d]};
    endfunction

    int   dut_bursts [2];
    logic prev_oe    [2];
    logic prev_dqs   [2];
    logic prev_ck    [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            dut_bursts[d] = 0; prev_oe[d] = 0; prev_dqs[d] = 0; prev_ck[d] = 0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    prev_oe[d] = 0; prev_dqs[d] = 0; prev_ck[d] = 0;
                end
            end else begin
                for (int d = 0; d < 2; d++) begin
                    logic [7:0] e;
                    logic [7:0] beat;
                    chk("pins", d, 64'(pins[d]), 64'(exp_pins(d)));
                    if (pins[d][2]) begin
                        if (!prev_oe[d]) begin
                            dut_bursts[d]++;
                            chk("first_beat_edge", d, 64'(m_n[d]), 64'(2*wl_of(d)));
                        end
                        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                            chk("dq_unexpected_beat", d, 64'(dqv[d]), 64'hx);
                        end else begin
                            beat = (d == 0) ? q0.pop_front() : q1.pop_front();
                            chk("dq_beat", d, 64'(dqv[d]), 64'(beat));
                        end
                    end else begin
                        chk("dq_idle_zero", d, 64'(dqv[d]), 64'h0);
                    end
                    if (!prev_dqs[d] && pins[d][4])
                        chk("dqs_rise_on_ck_rise", d, 64'({prev_ck[d], pins[d][7]}), 64'b01);
                    e           = pins[d];
                    prev_oe[d]  = e[2];
                    prev_dqs[d] = e[4];
                    prev_ck[d]  = e[7];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int d, input logic [63:0] v);
        int a0;
        a0     = m_acc[d];
        dat[d] = v;
        vld[d] = 1'b1;
        for (int i = 0; i < 64 && m_acc[d] == a0; i++) step();
        vld[d] = 1'b0;
        if (m_acc[d] == a0) chk("accept_timeout", d, 64'(m_acc[d]), 64'(a0 + 1));
    endtask

    task automatic settle(input int d);
        repeat (2*wl_of(d) + bl_of(d) + 3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        vld[0] = 0; vld[1] = 0; dat[0] = '0; dat[1] = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_pins", 0, 64'(pins[0]), 64'b0100_1001);
        chk("reset_pins", 1, 64'(pins[1]), 64'b0100_1001);
        chk("reset_dq", 0, 64'(dqv[0]), 64'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // single burst, WL=5 BL=8
        issue(0, 64'h0706050403020100);
        settle(0);
        chk("bursts_single", 0, 64'(dut_bursts[0]), 64'd1);

        // single burst, WL=2 BL=4
        issue(1, 64'h00000000_DDCCBBAA);
        settle(1);
        chk("bursts_single", 1, 64'(dut_bursts[1]), 64'd1);

        // request raised while ck_t=1: accept slips to the next CK rising edge
        while (!m_ck[0]) step();
        issue(0, 64'h1122334455667788);
        settle(0);
        chk("bursts_late_valid", 0, 64'(dut_bursts[0]), 64'd2);

        // valid held high for three back-to-back bursts
        a0     = m_acc[0];
        dat[0] = 64'hA5A5_5A5A_0FF0_F00F;
        vld[0] = 1'b1;
        for (int i = 0; i < 200 && m_acc[0] < a0 + 3; i++) step();
        vld[0] = 1'b0;
        chk("accepts_held", 0, 64'(m_acc[0]), 64'(a0 + 3));
        settle(0);
        chk("bursts_held", 0, 64'(dut_bursts[0]), 64'd5);

        // reset at edge 12 of a burst
        issue(0, 64'hFEDCBA9876543210);
        for (int i = 0; i < 40 && m_n[0] < 12; i++) step();
        rst_n = 1'b0;
        #1;
        chk("midburst_reset_pins", 0, 64'(pins[0]), 64'b0100_1001);
        chk("midburst_reset_dq", 0, 64'(dqv[0]), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        issue(0, 64'h0F1E2D3C4B5A6978);
        settle(0);
        chk("bursts_after_reset", 0, 64'(dut_bursts[0]), 64'd7);

        // random payloads and gaps
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 3)) step();
            issue(0, {$urandom, $urandom});
        end
        settle(0);
        chk("bursts_random", 0, 64'(dut_bursts[0]), 64'd107);
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) step();
            issue(1, {32'h0, $urandom});
        end
        settle(1);
        chk("bursts_random", 1, 64'(dut_bursts[1]), 64'd21);
        chk("queue_drained", 0, 64'(q0.size()), 64'd0);
        chk("queue_drained", 1, 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
